// File: rtl/unidad_de_detencion.sv
// Pipeline interlock: load-use bubbles, data-memory wait freeze with timeout,
// EXE branch squash, and a saturating stall-cycle counter.
module unidad_de_detencion #(
  parameter int unsigned REG_W       = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rp_dec,
  input  logic [REG_W-1:0] rs_dec,
  input  logic             usa_rp_dec,
  input  logic             usa_rs_dec,
  input  logic [REG_W-1:0] rg_exe,
  input  logic             carga_exe,
  input  logic             prohib_exe,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             salto_exe,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             burbuja_id_exe,
  output logic             flush_if_id,
  output logic             stall_back,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic                mw;
  logic                lu;

  assign mw = mem_req & ~mem_ready;
  assign lu = carga_exe & ~prohib_exe &
              ((usa_rp_dec & (rp_dec == rg_exe)) | (usa_rs_dec & (rs_dec == rg_exe)));

  // Next-state logic and same-cycle control decode
  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    stall_pc       = 1'b0;
    stall_if_id    = 1'b0;
    burbuja_id_exe = 1'b0;
    flush_if_id    = 1'b0;
    stall_back     = 1'b0;

    case (state)
      IDLE: begin
        if (mw) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mw) begin
          if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            state_nxt = ERROR;
          end else begin
            wait_cnt_nxt = WAIT_W'(wait_cnt + 1'b1);
          end
        end else begin
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end
      end
      ERROR:   state_nxt = ERROR;
      default: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = '0;
      end
    endcase

    // A frozen pipe defers branch and load-use handling until it moves again
    if (rst) begin
      stall_pc = 1'b0;
    end else if ((state == ERROR) || mw) begin
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
      stall_back  = 1'b1;
    end else if (salto_exe) begin
      flush_if_id    = 1'b1;
      burbuja_id_exe = 1'b1;
    end else if (lu) begin
      stall_pc       = 1'b1;
      stall_if_id    = 1'b1;
      burbuja_id_exe = 1'b1;
    end
  end

  // State, wait counter, sticky timeout flag and performance counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      mem_timeout <= mem_timeout | (state_nxt == ERROR);
      if (stall_pc && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= CNT_W'(stall_cnt + 1'b1);
      end
    end
  end

endmodule

// File: tb/tb_unidad_de_detencion.sv
// Self-checking bench for unidad_de_detencion: vector table, directed corner
// sequences and randomized traffic against a cycle-level reference model.
module tb_unidad_de_detencion;

  localparam int unsigned REG_W = 4;
  localparam int unsigned TMO   = 4;
  localparam int unsigned CW    = 4;
  localparam int          CMAX  = 15;

  typedef struct packed {
    logic [3:0] rp;
    logic [3:0] rs;
    logic       urp;
    logic       urs;
    logic [3:0] rg;
    logic       carga;
    logic       prohib;
    logic       req;
    logic       ready;
    logic       salto;
    logic       rst;
  } in_t;

  // {stall_pc, stall_if_id, burbuja_id_exe, flush_if_id, stall_back}
  typedef logic [4:0] out_t;

  typedef struct {
    string name;
    in_t   v;
    out_t  exp;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] rp_dec, rs_dec, rg_exe;
  logic             usa_rp_dec, usa_rs_dec, carga_exe, prohib_exe;
  logic             mem_req, mem_ready, salto_exe;
  logic             stall_pc, stall_if_id, burbuja_id_exe, flush_if_id, stall_back;
  logic             mem_timeout;
  logic [CW-1:0]    stall_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_err;
  int m_run;
  int m_cnt;

  always #5 clk = ~clk;

  unidad_de_detencion #(.REG_W(REG_W), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rp_dec(rp_dec), .rs_dec(rs_dec),
    .usa_rp_dec(usa_rp_dec), .usa_rs_dec(usa_rs_dec),
    .rg_exe(rg_exe), .carga_exe(carga_exe), .prohib_exe(prohib_exe),
    .mem_req(mem_req), .mem_ready(mem_ready), .salto_exe(salto_exe),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id),
    .burbuja_id_exe(burbuja_id_exe), .flush_if_id(flush_if_id),
    .stall_back(stall_back), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  function automatic in_t vec(input int rp, input int rs, input bit urp, input bit urs,
                              input int rg, input bit carga, input bit prohib,
                              input bit req, input bit ready, input bit salto, input bit r);
    in_t v;
    v.rp = 4'(rp); v.rs = 4'(rs); v.urp = urp; v.urs = urs; v.rg = 4'(rg);
    v.carga = carga; v.prohib = prohib; v.req = req; v.ready = ready;
    v.salto = salto; v.rst = r;
    return v;
  endfunction

  function automatic out_t model_ctrl(input in_t v);
    bit hit;
    hit = v.carga && !v.prohib &&
          ((v.urp && v.rp == v.rg) || (v.urs && v.rs == v.rg));
    if (v.rst)                           return 5'b00000;
    if (m_err || (v.req && !v.ready))    return 5'b11001;
    if (v.salto)                         return 5'b00110;
    if (hit)                             return 5'b11100;
    return 5'b00000;
  endfunction

  function automatic void model_step(input in_t v, input out_t o);
    if (v.rst) begin
      m_err = 0; m_run = 0; m_cnt = 0;
      return;
    end
    if (o[4] && m_cnt < CMAX) m_cnt++;
    if (!m_err) begin
      if (v.req && !v.ready) begin
        m_run++;
        if (m_run > int'(TMO)) m_err = 1;
      end else begin
        m_run = 0;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic out_t dut_ctrl();
    return {stall_pc, stall_if_id, burbuja_id_exe, flush_if_id, stall_back};
  endfunction

  // Drive one cycle, compare every output against the model before the edge
  task automatic apply(input in_t v, input string name);
    out_t e;
    @(negedge clk);
    rp_dec = v.rp; rs_dec = v.rs; usa_rp_dec = v.urp; usa_rs_dec = v.urs;
    rg_exe = v.rg; carga_exe = v.carga; prohib_exe = v.prohib;
    mem_req = v.req; mem_ready = v.ready; salto_exe = v.salto; rst = v.rst;
    #1;
    e = model_ctrl(v);
    chk({name, " ctrl"}, 32'(dut_ctrl()), 32'(e));
    chk({name, " mem_timeout"}, 32'(mem_timeout), 32'(m_err));
    chk({name, " stall_cnt"}, 32'(stall_cnt), 32'(m_cnt));
    model_step(v, e);
  endtask

  in_t  idle, rst_v, lu_v, mw_v, rdy_v;
  vec_t tab[$];

  initial begin
    idle  = vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_v = vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    lu_v  = vec(3, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0);
    mw_v  = vec(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    rdy_v = vec(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);

    tab.push_back('{"lu_rp",       lu_v,                                      5'b11100});
    tab.push_back('{"lu_prohib",   vec(3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0),      5'b00000});
    tab.push_back('{"lu_unused",   vec(3, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0),      5'b00000});
    tab.push_back('{"lu_rs",       vec(1, 7, 1, 1, 7, 1, 0, 0, 0, 0, 0),      5'b11100});
    tab.push_back('{"no_load",     vec(3, 3, 1, 1, 3, 0, 0, 0, 0, 0, 0),      5'b00000});
    tab.push_back('{"rg_miss",     vec(2, 5, 1, 1, 3, 1, 0, 0, 0, 0, 0),      5'b00000});
    tab.push_back('{"salto",       vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0),      5'b00110});
    tab.push_back('{"salto_lu",    vec(3, 0, 1, 0, 3, 1, 0, 0, 0, 1, 0),      5'b00110});
    tab.push_back('{"mw_one",      mw_v,                                      5'b11001});
    tab.push_back('{"mem_ready",   rdy_v,                                     5'b00000});
    tab.push_back('{"mw_lu",       vec(3, 0, 1, 0, 3, 1, 0, 1, 0, 0, 0),      5'b11001});
    tab.push_back('{"rst_force",   vec(3, 0, 1, 0, 3, 1, 0, 1, 0, 1, 1),      5'b00000});

    // initial reset; registers are unknown until the first edge
    rst = 1'b1;
    rp_dec = '0; rs_dec = '0; rg_exe = '0; usa_rp_dec = 0; usa_rs_dec = 0;
    carga_exe = 0; prohib_exe = 0; mem_req = 0; mem_ready = 0; salto_exe = 0;
    repeat (2) @(posedge clk);
    m_err = 0; m_run = 0; m_cnt = 0;

    apply(idle, "reset_state");
    chk("reset ctrl zero", 32'(dut_ctrl()), 32'd0);

    // single-cycle load-use costs exactly one counted stall
    apply(lu_v, "lu_once");
    apply(idle, "lu_after");
    chk("lu ctrl released", 32'(dut_ctrl()), 32'd0);
    chk("lu stall_cnt", 32'(stall_cnt), 32'd1);

    foreach (tab[i]) begin
      apply(tab[i].v, tab[i].name);
      chk({tab[i].name, " table"}, 32'(dut_ctrl()), 32'(tab[i].exp));
    end

    // three not-ready cycles then ready
    apply(rst_v, "mwait_rst");
    for (int i = 0; i < 3; i++) begin
      apply(mw_v, "mwait");
      chk("mwait freeze", 32'(dut_ctrl()), 32'b11001);
    end
    apply(rdy_v, "mwait_ready");
    chk("mwait ready free", 32'(dut_ctrl()), 32'd0);
    apply(idle, "mwait_done");
    chk("mwait stall_cnt", 32'(stall_cnt), 32'd3);

    // a branch during a freeze is acted on only once memory is ready
    apply(rst_v, "br_mw_rst");
    repeat (2) apply(vec(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), "br_mw");
    apply(vec(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0), "br_ready");
    chk("br_ready flush", 32'(dut_ctrl()), 32'b00110);

    // timeout: TMO+1 mw cycles latch the error; only reset clears it
    apply(rst_v, "tmo_rst");
    for (int i = 0; i < int'(TMO); i++) apply(mw_v, "tmo_pre");
    apply(mw_v, "tmo_last");
    chk("tmo not yet", 32'(mem_timeout), 32'd0);
    apply(idle, "tmo_err");
    chk("tmo flag", 32'(mem_timeout), 32'd1);
    chk("tmo sticky stall", 32'(dut_ctrl()), 32'b11001);
    apply(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), "tmo_clear");
    chk("tmo rst ctrl", 32'(dut_ctrl()), 32'd0);
    apply(idle, "tmo_after");
    chk("tmo after flag", 32'(mem_timeout), 32'd0);
    chk("tmo after cnt", 32'(stall_cnt), 32'd0);
    chk("tmo after ctrl", 32'(dut_ctrl()), 32'd0);

    // counter saturation
    apply(rst_v, "sat_rst");
    repeat (20) apply(lu_v, "sat_lu");
    apply(idle, "sat_end");
    chk("sat stall_cnt", 32'(stall_cnt), 32'(CMAX));

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      in_t v;
      v.rp     = 4'($urandom_range(3));
      v.rs     = 4'($urandom_range(3));
      v.urp    = 1'($urandom);
      v.urs    = 1'($urandom);
      v.rg     = 4'($urandom_range(3));
      v.carga  = 1'($urandom);
      v.prohib = ($urandom_range(3) == 0);
      v.req    = ($urandom_range(2) == 0);
      v.ready  = ($urandom_range(3) != 0);
      v.salto  = ($urandom_range(4) == 0);
      v.rst    = ($urandom_range(63) == 0);
      if (i % 500 == 250) begin
        for (int k = 0; k < 7; k++) apply(mw_v, "rand_tmo");
      end
      apply(v, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
